rmp_sml_chk: RTL and testbench
==============================

# rmp_sml_chk

Receive-side checker for the stepped DAC test waveform (levels 0, +step, +2·step, +step, 0, −step, −2·step, −step about an offset). It takes ADC samples of the looped-back DAC output, locks to the waveform's phase, and compares every sample against the expected level. It reports lock status, a saturating error count, the worst-case deviation and a once-per-period strobe. It sits on the ADC capture path, alongside the fast-DAC stepped-waveform source, and is used to qualify carry transitions end-to-end.

## Interface
- SKIP, 4: samples at the start of every segment excluded from comparison (analog settling).
- LOSS, 16: consecutive out-of-tolerance compared samples that force loss of lock.
- clk  in  1  sample clock, same as the source generator.
- rst  in  1  asynchronous, active-high reset.
- N  in  32  dwell per segment in clk cycles; must equal the generator's N; 0 = disabled.
- step  in  signed 16  step size, same as the generator.
- offset  in  signed 16  offset, same as the generator.
- tol  in  unsigned 16  allowed |sample − expected|.
- clr  in  1  synchronous clear of err_cnt, max_err and the LOSS run counter; lock is unaffected.
- in  in  signed 16  ADC sample.
- locked  out  1  high while in TRACK.
- err_cnt  out  16  compared samples out of tolerance while locked; saturates at 65535.
- max_err  out  16  largest |diff| seen among compared samples while locked; saturates at 65535.
- period_done  out  1  one-cycle pulse at the end of each tracked 60-segment period.

## Operation
- **Pattern:** 8 phases p0–p7.
  - Levels, in units of step: 0, +1, +2, +1, 0, −1, −2, −1.
  - Durations in segments: 8, 10, 2, 10, 8, 10, 2, 10. Total 60 segments.
  - Each segment lasts N cycles.
  - Expected value = offset + level·step.
- **Arithmetic:**
  - Expected value computed in 18-bit signed; 2·step is an arithmetic shift.
  - diff = in − expected, computed in 19-bit signed.
  - |diff| is compared against zero-extended tol.
  - max_err takes min(|diff|, 65535).
- **FSM IDLE:** entered when N==0, from any state, within one cycle. All counters cleared, locked=0.
- **FSM ACQ:** the previous registered sample is within tol of offset+step and the current sample is within tol of offset+2·step.
  - This condition marks cycle 0 of a p2 segment.
  - On detection, go to TRACK with phase=p2, seg=0, dwell=1.
- **FSM TRACK:** dwell counts 0..N−1; on wrap, seg advances, and on its own wrap, phase advances p7→p0.
  - Samples with dwell < SKIP are not compared; this includes every sample when N ≤ SKIP.
  - Compared sample out of tolerance: err_cnt++, run counter++.
  - Compared sample within tolerance: run counter cleared.
  - run counter reaching LOSS: go to ACQ, locked=0; err_cnt and max_err are held.
- **period_done:** pulses on the cycle the tracker wraps p7 last segment → p0.
- **N change mid-TRACK:** takes effect on the next dwell compare. The bench must re-lock by toggling N through 0.
- **clr in the same cycle as an error:** clr wins, and the counter reads 0.

## Timing
- Reset values: locked=0, err_cnt=0, max_err=0, period_done=0, FSM=IDLE (then ACQ if N≠0), all counters 0.
- in is registered once (in_r); comparison is registered once.
- err_cnt, max_err and locked reflect a sample 2 cycles after it is presented on in.
- Lock asserts 2 cycles after the first +2·step sample.
- period_done is aligned with the tracker counter, 1 cycle after the wrap.
- rst assertion mid-TRACK clears everything asynchronously. After release, the block reacquires from ACQ.

## Test plan
- **Ideal lock:** ideal loopback (generator model), N=4, step=1000, offset=−500, tol=0.
  - locked rises 2 cycles after the first sample equal to 1500.
  - err_cnt stays 0 and max_err stays 0.
  - period_done pulses every 240 cycles.
- **Single glitch:** same setup, tol=50, add +100 to one mid-segment sample (dwell ≥ SKIP). Result: err_cnt=1, max_err=100, locked stays 1.
- **Settling excluded:** a +3000 spike on dwell 0..SKIP−1 of a segment. Result: err_cnt=0.
- **Loss of lock:** force in=0 after lock, step=1000, tol=10.
  - locked falls after 16 consecutive compared errors.
  - err_cnt holds.
  - Restoring the waveform relocks at the next p2.
- **Disable and clear:** N=0 → locked=0, FSM in IDLE. clr=1 → err_cnt=0, max_err=0 the next cycle.
- **Reset and saturation:** assert rst mid-TRACK → all outputs 0 immediately. Drive constant offset with a ±32767 step and tol=0 while locked.
  - err_cnt saturates at 65535.
  - max_err saturates at 65535.

Source files
------------

// File: rtl/rmp_sml_chk.sv
// rmp_sml_chk: receive-side checker for the stepped DAC test waveform.
// Locks to the waveform phase, scores settled samples, reports lock/errors.
module rmp_sml_chk #(
    parameter int SKIP = 4,
    parameter int LOSS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic        [31:0] N,
    input  logic signed [15:0] step,
    input  logic signed [15:0] offset,
    input  logic        [15:0] tol,
    input  logic               clr,
    input  logic signed [15:0] in,
    output logic               locked,
    output logic        [15:0] err_cnt,
    output logic        [15:0] max_err,
    output logic               period_done
);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    state_t             st;
    logic signed [15:0] in_r;
    logic signed [15:0] in_p;
    logic        [2:0]  ph;
    logic        [3:0]  seg;
    logic        [31:0] dw;
    logic        [4:0]  run;

    logic signed [17:0] off18;
    logic signed [17:0] step18;
    logic signed [17:0] step2;
    logic signed [17:0] lvl;
    logic signed [17:0] expv;
    logic signed [17:0] exp1;
    logic signed [17:0] exp2;
    logic        [3:0]  dur;
    logic        [18:0] mag;
    logic        [15:0] mag16;
    logic               bad;
    logic               cmp_en;
    logic               dw_last;
    logic               seg_last;
    logic               acq_hit;

    function automatic logic [18:0] absdiff(
        input logic signed [15:0] x,
        input logic signed [17:0] e
    );
        logic signed [18:0] d;
        logic        [18:0] u;
        d = {{3{x[15]}}, x} - {e[17], e};
        u = d;
        return d[18] ? (~u + 19'd1) : u;
    endfunction

    // expected level for the tracked phase, plus the two lock-detect levels
    always_comb begin
        off18  = {{2{offset[15]}}, offset};
        step18 = {{2{step[15]}}, step};
        step2  = step18 <<< 1;
        lvl    = '0;
        unique case (ph)
            3'd1, 3'd3: lvl = step18;
            3'd2:       lvl = step2;
            3'd5, 3'd7: lvl = -step18;
            3'd6:       lvl = -step2;
            default:    lvl = '0;
        endcase
        expv = off18 + lvl;
        exp1 = off18 + step18;
        exp2 = off18 + step2;
    end

    // segments per phase
    always_comb begin
        dur = 4'd10;
        unique case (ph)
            3'd0, 3'd4: dur = 4'd8;
            3'd2, 3'd6: dur = 4'd2;
            default:    dur = 4'd10;
        endcase
    end

    assign mag      = absdiff(in_r, expv);
    assign bad      = mag > {3'b000, tol};
    assign mag16    = (|mag[18:16]) ? 16'hFFFF : mag[15:0];
    assign cmp_en   = dw >= 32'(SKIP);
    assign dw_last  = dw >= (N - 32'd1);
    assign seg_last = seg == (dur - 4'd1);
    assign acq_hit  = (absdiff(in_p, exp1) <= {3'b000, tol}) &&
                      (absdiff(in_r, exp2) <= {3'b000, tol});

    // sample pipeline, lock FSM, phase tracker and error scoring
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            in_r        <= '0;
            in_p        <= '0;
            ph          <= '0;
            seg         <= '0;
            dw          <= '0;
            run         <= '0;
            locked      <= 1'b0;
            err_cnt     <= '0;
            max_err     <= '0;
            period_done <= 1'b0;
        end else begin
            in_r        <= in;
            in_p        <= in_r;
            period_done <= 1'b0;
            if (N == 32'd0) begin
                st     <= IDLE;
                locked <= 1'b0;
                ph     <= '0;
                seg    <= '0;
                dw     <= '0;
                run    <= '0;
            end else begin
                unique case (st)
                    IDLE: st <= ACQ;
                    ACQ: begin
                        if (acq_hit) begin
                            st     <= TRACK;
                            locked <= 1'b1;
                            ph     <= 3'd2;
                            seg    <= '0;
                            dw     <= 32'd1;
                            run    <= '0;
                        end
                    end
                    TRACK: begin
                        if (dw_last) begin
                            dw <= '0;
                            if (seg_last) begin
                                seg         <= '0;
                                ph          <= ph + 3'd1;
                                period_done <= (ph == 3'd7);
                            end else begin
                                seg <= seg + 4'd1;
                            end
                        end else begin
                            dw <= dw + 32'd1;
                        end
                        if (cmp_en) begin
                            if (mag16 > max_err)
                                max_err <= mag16;
                            if (bad) begin
                                if (err_cnt != 16'hFFFF)
                                    err_cnt <= err_cnt + 16'd1;
                                if (run == 5'(LOSS - 1)) begin
                                    st     <= ACQ;
                                    locked <= 1'b0;
                                    run    <= '0;
                                end else begin
                                    run <= run + 5'd1;
                                end
                            end else begin
                                run <= '0;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
            if (clr) begin
                err_cnt <= '0;
                max_err <= '0;
                run     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rmp_sml_chk.sv
// tb_rmp_sml_chk: directed bench for rmp_sml_chk with a generator model
// and an expectation queue.
`timescale 1ns/1ps
module tb_rmp_sml_chk;

    logic               clk = 1'b0;
    logic               rst;
    logic        [31:0] N;
    logic signed [15:0] step;
    logic signed [15:0] offset;
    logic        [15:0] tol;
    logic               clr;
    logic signed [15:0] in;
    logic               locked;
    logic        [15:0] err_cnt;
    logic        [15:0] max_err;
    logic               period_done;

    rmp_sml_chk dut (
        .clk(clk), .rst(rst), .N(N), .step(step), .offset(offset),
        .tol(tol), .clr(clr), .in(in), .locked(locked),
        .err_cnt(err_cnt), .max_err(max_err), .period_done(period_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    int lv[8] = '{0, 1, 2, 1, 0, -1, -2, -1};
    int du[8] = '{8, 10, 2, 10, 8, 10, 2, 10};
    int gph, gseg, gdw, gn, gstep, goff;
    int nerr, ci;

    function automatic int gen_val();
        return goff + lv[gph] * gstep;
    endfunction

    task automatic gen_rst();
        gph = 0; gseg = 0; gdw = 0;
    endtask

    task automatic gen_adv();
        gdw++;
        if (gdw == gn) begin
            gdw = 0;
            gseg++;
            if (gseg == du[gph]) begin
                gseg = 0;
                gph  = (gph + 1) % 8;
            end
        end
    endtask

    task automatic setw(input int n, input int st, input int of, input int tl);
        N = 32'(n); step = 16'(st); offset = 16'(of); tol = 16'(tl);
        gn = n; gstep = st; goff = of;
    endtask

    task automatic cyc(input int inj = 0, input bit frc = 0, input int fv = 0);
        in = frc ? 16'(fv) : 16'(gen_val() + inj);
        @(posedge clk);
        #1;
        gen_adv();
    endtask

    task automatic push(input string t, input int s, input int e);
        exp_t x;
        x.tag = t; x.sel = s; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic chk();
        exp_t        x;
        logic [31:0] obs;
        x = sb.pop_front();
        case (x.sel)
            0:       obs = {31'b0, locked};
            1:       obs = {16'b0, err_cnt};
            2:       obs = {16'b0, max_err};
            default: obs = {31'b0, period_done};
        endcase
        ntests++;
        assert (obs === 32'(x.exp)) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.exp);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in = '0;
        setw(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        push("rst_lock", 0, 0); push("rst_err", 1, 0);
        push("rst_max", 2, 0);  push("rst_pd", 3, 0);
        repeat (4) chk();
        @(negedge clk);
        rst = 1'b0;

        // ideal lock, N=4
        setw(4, 1000, -500, 0); gen_rst();
        push("lock_pre", 0, 0);
        repeat (73) cyc();
        chk();
        push("lock_rise", 0, 1);
        cyc(); chk();
        repeat (166) cyc();
        push("pd_pre", 3, 0); chk();
        push("pd_first", 3, 1); cyc(); chk();
        push("pd_end", 3, 0); cyc(); chk();
        repeat (238) cyc();
        push("pd_second", 3, 1); cyc(); chk();
        push("ideal_err", 1, 0); push("ideal_max", 2, 0);
        chk(); chk();

        // relock at N=8, settling spike then glitch
        N = '0; gn = 0;
        push("dis_lock", 0, 0); cyc(0, 1, 0); chk();
        setw(8, 1000, -500, 50); gen_rst();
        push("lock8", 0, 1);
        repeat (146) cyc();
        chk();
        repeat (14) cyc();
        repeat (4) cyc(3000);
        push("settle_err", 1, 0);
        repeat (2) cyc();
        chk();
        cyc(100);
        push("glitch_err", 1, 1); push("glitch_max", 2, 100);
        push("glitch_lock", 0, 1);
        cyc(); chk(); chk(); chk();

        // loss of lock with in forced to 0
        tol = 16'd10;
        repeat (32) cyc();
        repeat (32) cyc(0, 1, 0);
        push("loss_pre", 0, 1); push("loss_err16", 1, 16);
        chk(); chk();
        push("loss_fall", 0, 0); push("loss_err", 1, 17);
        cyc(0, 1, 0); chk(); chk();
        repeat (7) cyc(0, 1, 0);
        repeat (385) cyc();
        push("relock_pre", 0, 0); chk();
        push("relock", 0, 1); push("err_hold", 1, 17);
        cyc(); chk(); chk();

        // disable and clear
        N = '0; gn = 0;
        push("idle_lock", 0, 0); cyc(0, 1, 0); chk();
        clr = 1'b1;
        push("clr_err", 1, 0); push("clr_max", 2, 0);
        cyc(0, 1, 0);
        clr = 1'b0;
        chk(); chk();

        // err_cnt saturation with runs kept below the loss threshold
        setw(128, 1000, -500, 0); gen_rst();
        push("lock128", 0, 1);
        repeat (2306) cyc();
        chk();
        nerr = 0; ci = 0;
        while (nerr < 65540) begin
            if (gdw >= 4) begin
                if (ci % 16 != 15) begin
                    cyc(1); nerr++;
                end else begin
                    cyc();
                end
                ci++;
            end else begin
                cyc();
            end
        end
        push("sat_err", 1, 65535); push("sat_lock", 0, 1);
        push("sat_max1", 2, 1);
        repeat (2) cyc();
        chk(); chk(); chk();

        // max_err saturation via an extreme step/offset for one sample
        while (!(lv[gph] >= 0 && gdw == 6)) cyc();
        step = 16'sd32767; offset = 16'sd32767;
        cyc(0, 1, -32768);
        cyc();
        step = 16'sd1000; offset = -16'sd500;
        push("max_sat", 2, 65535); push("err_sat2", 1, 65535);
        push("lock_sat", 0, 1);
        cyc(); chk(); chk(); chk();

        // clr in the same cycle as a scored error
        cyc(1);
        clr = 1'b1;
        push("clr_race_err", 1, 0); push("clr_race_max", 2, 0);
        cyc();
        clr = 1'b0;
        chk(); chk();
        push("post_clr", 1, 0); cyc(); chk();

        // asynchronous reset mid-track, then reacquire
        cyc(1);
        push("pre_rst_err", 1, 1); cyc(); chk();
        #2 rst = 1'b1;
        #1;
        push("arst_lock", 0, 0); push("arst_err", 1, 0);
        push("arst_max", 2, 0);  push("arst_pd", 3, 0);
        repeat (4) chk();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        setw(4, 1000, -500, 0); gen_rst();
        push("reacq_pre", 0, 0);
        repeat (73) cyc();
        chk();
        push("reacq", 0, 1); cyc(); chk();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
